// File: rtl/ram_write_buffer_ctrl_pkg.sv
// Shared constants and types for the RAM write-buffer controller.
// Request mode encoding, RAM port FSM states, and default index/pointer widths.
package ram_write_buffer_ctrl_pkg;
  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int DEF_MEM_DEPTH = 4096;
  localparam int DEF_WB_DEPTH  = 4;
  localparam int IDX_W = $clog2(DEF_MEM_DEPTH);
  localparam int PTR_W = $clog2(DEF_WB_DEPTH);

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_WR_BUSY,
    PS_RD_BUSY
  } port_state_e;
endpackage

// File: rtl/ram_write_buffer_ctrl_if.sv
// Cache-facing request/response bundle of the backing-store stage.
// master = cache side, slave = controller side.
interface ram_write_buffer_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_mode;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_data, req_mode,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_mode,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/ram_write_buffer_ctrl_write_buffer_fifo.sv
// Circular write buffer with a combinational youngest-match lookup port.
// Entries stay searchable until the edge that pops them.
module write_buffer_fifo
  import ram_write_buffer_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEF_WB_DEPTH,
  parameter int IW     = IDX_W,
  parameter int DATA_W = 32,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [IW-1:0]     push_idx,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [IW-1:0]     head_idx,
  output logic [DATA_W-1:0] head_data,
  input  logic [IW-1:0]     look_idx,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);
  logic [PW-1:0]     head, tail;
  logic [PW:0]       count;
  logic [IW-1:0]     idx_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     p;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      idx_q[tail]  <= push_idx;
      data_q[tail] <= push_data;
    end
  end

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_idx  = idx_q[head];
  assign head_data = data_q[head];

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    p        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      p = head + PW'(i);
      if (((PW+1)'(i) < count) && (idx_q[p] == look_idx)) begin
        hit      = 1'b1;
        hit_data = data_q[p];
      end
    end
  end
endmodule

// File: rtl/ram_write_buffer_ctrl.sv
// Backing-store stage behind the cache: buffers writes, forwards read hits,
// and serialises drains and read misses onto a fixed-latency single-port RAM.
module ram_write_buffer_ctrl
  import ram_write_buffer_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int WB_DEPTH    = DEF_WB_DEPTH,
  parameter int RAM_LATENCY = 3
) (
  input  logic clk,
  input  logic reset,
  ram_write_buffer_ctrl_if.slave bus
);
  localparam int IW    = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(RAM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY - 1);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              full, empty, hit;
  logic [IW-1:0]     req_idx, head_idx, rd_idx;
  logic [DATA_W-1:0] head_data, hit_data;
  logic              accept, wr_acc, rd_acc, rd_miss;
  logic              rd_pending, drain_done, read_done;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  port_state_e       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  assign req_idx = bus.req_addr[IW-1:0];

  if (ADDR_W > IW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:IW];
  end

  assign bus.req_ready  = !full && !rd_pending;
  assign accept         = bus.req_valid && bus.req_ready;
  assign wr_acc         = accept && (bus.req_mode == MODE_WRITE);
  assign rd_acc         = accept && (bus.req_mode == MODE_READ);
  assign rd_miss        = rd_acc && !hit;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = !empty || (state != PS_IDLE);

  write_buffer_fifo #(
    .DEPTH (WB_DEPTH),
    .IW    (IW),
    .DATA_W(DATA_W)
  ) u_wbuf (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_acc),
    .push_idx (req_idx),
    .push_data(bus.req_data),
    .pop      (drain_done),
    .full     (full),
    .empty    (empty),
    .head_idx (head_idx),
    .head_data(head_data),
    .look_idx (req_idx),
    .hit      (hit),
    .hit_data (hit_data)
  );

  // A fresh miss in IDLE enters RD_BUSY on its accept edge; reads beat drains.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    drain_done = 1'b0;
    read_done  = 1'b0;
    case (state)
      PS_IDLE: begin
        if (rd_pending || rd_miss) begin
          state_nxt = PS_RD_BUSY;
          cnt_nxt   = CNT_LOAD;
        end else if (!empty) begin
          state_nxt = PS_WR_BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      PS_WR_BUSY: begin
        if (cnt == '0) begin
          drain_done = 1'b1;
          state_nxt  = PS_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      PS_RD_BUSY: begin
        if (cnt == '0) begin
          read_done = 1'b1;
          state_nxt = PS_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = PS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PS_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_idx     <= '0;
    end else if (rd_miss) begin
      rd_pending <= 1'b1;
      rd_idx     <= req_idx;
    end else if (read_done) begin
      rd_pending <= 1'b0;
    end
  end

  // rd_pending blocks acceptance, so these three sources never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if (wr_acc) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= bus.req_data;
      end else if (rd_acc && hit) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= hit_data;
      end else if (read_done) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (drain_done) mem[head_idx] <= head_data;
  end
endmodule

// File: tb/tb_ram_write_buffer_ctrl.sv
// Directed bench for ram_write_buffer_ctrl: vector table for immediate
// responses plus hand-written sequences for drain/miss/reset timing.
module tb_ram_write_buffer_ctrl;
  import ram_write_buffer_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ram_write_buffer_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ram_write_buffer_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_ready;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted; returns 1 time unit after the accept edge.
  task automatic issue(input logic mode, input logic [31:0] addr, input logic [31:0] data);
    int  waited;
    bit  got;
    bus.req_valid = 1'b1;
    bus.req_mode  = mode;
    bus.req_addr  = addr;
    bus.req_data  = data;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 50) begin
      @(negedge clk);
      if (bus.req_ready) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      n_assert++;
      n_fail++;
      $display("FAIL accept_timeout: addr %0d not accepted after %0d cycles", addr, waited);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      step();
      n++;
    end
    if (bus.busy) begin
      n_assert++;
      n_fail++;
      $display("FAIL idle_timeout: busy still %0d after %0d cycles", bus.busy, n);
    end
  endtask

  // Latency counts the accept cycle as 1.
  task automatic miss_read(input string tag, input logic [31:0] addr, input int exp_lat,
                           input logic [31:0] exp_data);
    int n;
    bit ready_seen;
    issue(MODE_READ, addr, 32'hdead_beef);
    n = 1;
    ready_seen = 1'b0;
    while (!bus.resp_valid && n < 30) begin
      if (bus.req_ready) ready_seen = 1'b1;
      step();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_data"}, bus.resp_data, exp_data);
    chk({tag, "_ready_low"}, {31'd0, ready_seen}, 32'd0);
  endtask

  initial begin
    int  idle_seen;
    bus.req_valid = 1'b0;
    bus.req_mode  = MODE_READ;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    tbl[0] = '{MODE_WRITE, 32'd2816867292, 32'd526421, 32'd526421, 1'b1};
    tbl[1] = '{MODE_READ,  32'd3036,       32'd0,      32'd526421, 1'b1};
    tbl[2] = '{MODE_WRITE, 32'd100,        32'd7,      32'd7,      1'b1};
    tbl[3] = '{MODE_WRITE, 32'd100,        32'd8,      32'd8,      1'b1};
    tbl[4] = '{MODE_READ,  32'd100,        32'd0,      32'd8,      1'b1};

    // 1: reset state, single write and its drain timing
    step();
    step();
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    issue(MODE_WRITE, 32'd0, 32'd14528);
    chk("t1_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("t1_resp_data", bus.resp_data, 32'd14528);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    step(); step(); step();
    chk("t1_busy_draining", {31'd0, bus.busy}, 32'd1);
    chk("t1_resp_pulse", {31'd0, bus.resp_valid}, 32'd0);
    step();
    chk("t1_busy_done", {31'd0, bus.busy}, 32'd0);

    // 2: echo and forwarding vectors, back to back
    for (int i = 0; i < 5; i++) begin
      issue(tbl[i].mode, tbl[i].addr, tbl[i].data);
      chk($sformatf("vec%0d_resp_valid", i), {31'd0, bus.resp_valid}, 32'd1);
      chk($sformatf("vec%0d_resp_data", i), bus.resp_data, tbl[i].exp_data);
      chk($sformatf("vec%0d_ready", i), {31'd0, bus.req_ready}, {31'd0, tbl[i].exp_ready});
    end
    wait_idle();

    // 3: read miss from idle port
    miss_read("t3", 32'd0, 4, 32'd14528);
    wait_idle();

    // 4: fill the buffer with same-index writes
    for (int v = 1; v <= 4; v++) begin
      issue(MODE_WRITE, 32'd2001, v);
      chk($sformatf("t4_echo%0d", v), bus.resp_data, v);
    end
    chk("t4_ready_full", {31'd0, bus.req_ready}, 32'd0);
    issue(MODE_WRITE, 32'd2001, 32'd5);
    chk("t4_echo5_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("t4_echo5", bus.resp_data, 32'd5);
    issue(MODE_READ, 32'd2001, 32'd0);
    chk("t4_hit_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("t4_hit_youngest", bus.resp_data, 32'd5);
    chk("t4_hit_ready", {31'd0, bus.req_ready}, 32'd1);
    wait_idle();
    miss_read("t4_ram", 32'd2001, 4, 32'd5);
    wait_idle();

    // 5: read miss waits behind an in-progress drain
    issue(MODE_WRITE, 32'd2001, 32'd25369366);
    step();
    miss_read("t5", 32'd0, 7, 32'd14528);
    wait_idle();
    miss_read("t5_ram", 32'd2001, 4, 32'd25369366);
    wait_idle();

    // 6: reset during RD_BUSY with three writes buffered
    issue(MODE_WRITE, 32'd50, 32'd77);
    issue(MODE_WRITE, 32'd2001, 32'd111);
    issue(MODE_WRITE, 32'd2001, 32'd222);
    issue(MODE_WRITE, 32'd2001, 32'd333);
    issue(MODE_READ, 32'd0, 32'd0);
    chk("t6_rd_pending", {31'd0, bus.req_ready}, 32'd0);
    chk("t6_busy_pre", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("t6_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("t6_resp_data", bus.resp_data, 32'd0);
    idle_seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.resp_valid || bus.busy) idle_seen++;
    end
    chk("t6_quiet_after_reset", idle_seen, 0);
    miss_read("t6_2001", 32'd2001, 4, 32'd25369366);
    wait_idle();
    miss_read("t6_50", 32'd50, 4, 32'd77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_write_buffer_ctrl.md
Name: ram_write_buffer_ctrl

Overview:
Backing-store stage directly downstream of the cache. It accepts the cache's miss-fill reads and write traffic and owns a single-port RAM model with fixed multi-cycle latency. Writes are absorbed into a small write buffer and drained to RAM in the background. Reads that hit in the buffer are forwarded, so the cache never sees stale RAM data.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data width
MEM_DEPTH, 4096, RAM words; index = req_addr % MEM_DEPTH (low log2 bits, power of two required)
WB_DEPTH, 4, write-buffer entries (power of two, >=2)
RAM_LATENCY, 3, cycles per RAM access (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted on edge where req_valid&&req_ready
req_addr  in  ADDR_W  byte/word address (only index bits used)
req_data  in  DATA_W  write data (ignored for reads)
req_mode  in  1  1 = write, 0 = read (codebase mode encoding)
resp_valid  out  1  one-cycle pulse, response present
resp_data  out  DATA_W  read data, or echoed write data
busy  out  1  buffer non-empty or RAM port not IDLE

Behaviour:
- Reset (sync, any state, mid-drain/mid-read included): buffer emptied, pending writes discarded, pending read dropped, FSM->IDLE. Outputs after the reset edge: req_ready=1, resp_valid=0, resp_data=0, busy=0. RAM contents are not touched by reset and power up to zero.
- req_ready = !buf_full && !rd_pending. Both terms are registered. It does not depend on req_valid or req_mode.
- Write accept at edge T: entry pushed at tail. resp_valid=1, resp_data=req_data in the cycle after T.
- Read accept at edge T: the index is compared against all valid buffer entries, including the one currently draining.
  - Hit: the youngest matching entry wins. resp_valid=1, resp_data=that data in the cycle after T.
  - Miss: rd_pending set, address latched.
- RAM port FSM, states IDLE, WR_BUSY, RD_BUSY. A down-counter loads RAM_LATENCY-1 on entry.
  - IDLE: rd_pending goes to RD_BUSY. Otherwise a non-empty buffer goes to WR_BUSY on the head entry. A read has priority over a drain.
  - WR_BUSY: at counter==0, write the head to RAM, pop the head, go to IDLE. The head stays visible for forwarding until the pop edge.
  - RD_BUSY: at counter==0, resp_valid=1, resp_data=RAM[idx] in the next cycle, clear rd_pending, go to IDLE.
  - A drain in progress is never pre-empted. A read miss waits for it to finish.
- Miss latency with port IDLE at accept: the accept edge moves the FSM straight to RD_BUSY. resp_valid is high in the cycle RAM_LATENCY+1 edges after acceptance (4 with defaults).
- Push and pop on the same edge are legal; the count is unchanged. A full buffer blocks writes even on a pop edge (conservative registered ready).
- Multiple writes to the same index are kept as separate entries and drained in order, so RAM ends with the last value.
- Index wrap: 2816867292 and 3036 alias to the same word. This is intended.
- At most one resp_valid per cycle, because the hit/write response and RD_BUSY completion cannot coincide: rd_pending blocks acceptance.

Decomposition:
- Shared package: MODE_READ=0 / MODE_WRITE=1 constants, port FSM state enum, clog2-derived IDX_W and PTR_W localparams.
- One sub-module, write_buffer_fifo: circular FIFO with head/tail/count plus a combinational youngest-match search port (hit, hit_data).

Test Plan:
1. Reset, then write addr 0 data 14528. Next cycle: resp_valid=1, resp_data=14528, busy=1. After RAM_LATENCY+1 cycles idle: busy=0.
2. Write 2816867292 data 526421, then immediately read 3036 (buffer hit). Response 1 cycle after accept = 526421, with no RD_BUSY entry.
3. Let the buffer drain, then read addr 0. resp_valid exactly 4 cycles after accept, data 14528. req_ready=0 throughout.
4. Issue 5 back-to-back writes to 2001 (values 1..5) with the port busy. req_ready drops after 4 accepted. Then read 2001 returns 5, and after the full drain RAM[2001]=5.
5. Start a drain of 2001=25369366, then read-miss 0. The read completes only after the drain (WR then RD order). Data 14528.
6. Assert reset mid-RD_BUSY with 3 writes buffered. No resp_valid follows, busy=0 next cycle, and the discarded writes never reach RAM (read of 2001 returns the old value).
